// File: rtl/j_scan_counter.sv
// 2-D pixel-coordinate generator: raster or BLKxBLK tiled walk over a programmable image.
// One-cycle latency from start/advance to coordinate; advance is honoured only while valid is high.
module j_scan_counter #(
  parameter int WIDTH = 13,
  parameter int BLK   = 8
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] img_width,
  input  logic [WIDTH-1:0] img_height,
  input  logic             advance,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] row,
  output logic [WIDTH-1:0] col,
  output logic             last,
  output logic             row_wrap,
  output logic             done,
  output logic             err
);

  localparam int OW = $clog2(BLK);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_n;
  logic             mode_q, mode_n;
  logic [WIDTH-1:0] w_q, w_n, h_q, h_n;
  logic [WIDTH-1:0] tx, tx_n, ty, ty_n;
  logic [OW-1:0]    ox, ox_n, oy, oy_n;
  logic             wrap_q, wrap_n;
  logic             err_q, err_n;
  logic             start_ok;

  // Raster mode keeps the offsets at zero and walks the tile origin one pixel at a time.
  assign col      = tx + WIDTH'(ox);
  assign row      = ty + WIDTH'(oy);
  assign busy     = (state == RUN);
  assign valid    = (state == RUN);
  assign done     = (state == DONE);
  assign err      = err_q;
  assign row_wrap = wrap_q;
  assign last     = (state == RUN) && (row == h_q - 1'b1) && (col == w_q - 1'b1);

  assign start_ok = (img_width != '0) && (img_height != '0) &&
                    (!mode || ((img_width[OW-1:0] == '0) && (img_height[OW-1:0] == '0)));

  always_ff @(posedge clk) begin
    if (clear) begin
      state  <= IDLE;
      mode_q <= 1'b0;
      w_q    <= '0;
      h_q    <= '0;
      tx     <= '0;
      ty     <= '0;
      ox     <= '0;
      oy     <= '0;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_n;
      mode_q <= mode_n;
      w_q    <= w_n;
      h_q    <= h_n;
      tx     <= tx_n;
      ty     <= ty_n;
      ox     <= ox_n;
      oy     <= oy_n;
      wrap_q <= wrap_n;
      err_q  <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    mode_n  = mode_q;
    w_n     = w_q;
    h_n     = h_q;
    tx_n    = tx;
    ty_n    = ty;
    ox_n    = ox;
    oy_n    = oy;
    wrap_n  = wrap_q;
    err_n   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (start_ok) begin
            state_n = RUN;
            mode_n  = mode;
            w_n     = img_width;
            h_n     = img_height;
            tx_n    = '0;
            ty_n    = '0;
            ox_n    = '0;
            oy_n    = '0;
            wrap_n  = 1'b0;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      RUN: begin
        if (advance) begin
          wrap_n = 1'b0;
          if (last) begin
            state_n = DONE;
            tx_n    = '0;
            ty_n    = '0;
            ox_n    = '0;
            oy_n    = '0;
          end else if (!mode_q) begin
            if (tx == w_q - 1'b1) begin
              tx_n   = '0;
              ty_n   = ty + 1'b1;
              wrap_n = 1'b1;
            end else begin
              tx_n = tx + 1'b1;
            end
          end else if (ox != OW'(BLK - 1)) begin
            ox_n = ox + 1'b1;
          end else if (oy != OW'(BLK - 1)) begin
            ox_n = '0;
            oy_n = oy + 1'b1;
          end else begin
            // Tile finished: step to the next tile, wrapping to the next tile row at the right edge.
            ox_n = '0;
            oy_n = '0;
            if (tx == w_q - WIDTH'(BLK)) begin
              tx_n   = '0;
              ty_n   = ty + WIDTH'(BLK);
              wrap_n = 1'b1;
            end else begin
              tx_n = tx + WIDTH'(BLK);
            end
          end
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_j_scan_counter.sv
// Scoreboard bench for j_scan_counter: reference walk order built from nested loops.
module tb_j_scan_counter;
  localparam int W   = 13;
  localparam int BLK = 8;

  logic         clk = 1'b0;
  logic         clear, start, mode, advance;
  logic [W-1:0] img_width, img_height;
  logic         busy, valid, last, row_wrap, done, err;
  logic [W-1:0] row, col;

  always #5 clk = ~clk;

  j_scan_counter #(.WIDTH(W), .BLK(BLK)) dut (
    .clk(clk), .clear(clear), .start(start), .mode(mode),
    .img_width(img_width), .img_height(img_height), .advance(advance),
    .busy(busy), .valid(valid), .row(row), .col(col), .last(last),
    .row_wrap(row_wrap), .done(done), .err(err)
  );

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] ref_q[$];

  // Observation layout: {valid, busy, row, col, last, row_wrap, done, err}
  localparam logic [31:0] IDLE_OBS = 32'h0;
  localparam logic [31:0] DONE_OBS = 32'h2;
  localparam logic [31:0] ERR_OBS  = 32'h1;

  function automatic logic [31:0] coord(input int r, input int c, input logic l, input logic wr);
    return {1'b1, 1'b1, W'(r), W'(c), l, wr, 1'b0, 1'b0};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, expv);
    end
  endtask

  task automatic cycle(input string tag, input logic [31:0] e);
    logic [31:0] want;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    want = exp_q.pop_front();
    check(tag, {valid, busy, row, col, last, row_wrap, done, err}, want);
  endtask

  task automatic build_ref(input logic m, input int w, input int h);
    ref_q.delete();
    if (!m) begin
      for (int r = 0; r < h; r++)
        for (int c = 0; c < w; c++)
          ref_q.push_back(coord(r, c, (r == h-1) && (c == w-1), (c == 0) && (r != 0)));
    end else begin
      for (int ty = 0; ty < h; ty += BLK)
        for (int tx = 0; tx < w; tx += BLK)
          for (int oy = 0; oy < BLK; oy++)
            for (int ox = 0; ox < BLK; ox++)
              ref_q.push_back(coord(ty+oy, tx+ox, (ty+oy == h-1) && (tx+ox == w-1),
                                    (ox == 0) && (oy == 0) && (tx == 0) && (ty != 0)));
    end
  endtask

  task automatic run_frame(input logic m, input int w, input int h, input int gap,
                           input int poke_at, input int abort_at);
    build_ref(m, w, h);
    mode = m; img_width = W'(w); img_height = W'(h); start = 1'b1;
    cycle("start", ref_q[0]);
    start = 1'b0;
    for (int i = 1; i <= ref_q.size(); i++) begin
      for (int g = 0; g < gap; g++) cycle($sformatf("hold[%0d]", i-1), ref_q[i-1]);
      if (i == poke_at) begin
        start = 1'b1; img_width = W'(2); mode = ~m;
        cycle($sformatf("ignored[%0d]", i-1), ref_q[i-1]);
        start = 1'b0;
      end
      if (i == abort_at) begin
        clear = 1'b1; advance = 1'b1;
        cycle("clear_mid", IDLE_OBS);
        clear = 1'b0; advance = 1'b0;
        cycle("after_clear", IDLE_OBS);
        return;
      end
      advance = 1'b1;
      if (i == ref_q.size()) cycle("done", DONE_OBS);
      else cycle($sformatf("adv[%0d]", i), ref_q[i]);
      advance = 1'b0;
    end
    cycle("post_idle", IDLE_OBS);
  endtask

  initial begin
    clear = 1'b1; start = 1'b0; mode = 1'b0; advance = 1'b0;
    img_width = '0; img_height = '0;
    cycle("reset", IDLE_OBS);
    start = 1'b1; advance = 1'b1;
    cycle("reset_wins", IDLE_OBS);
    clear = 1'b0; start = 1'b0; advance = 1'b0;

    run_frame(1'b0, 3, 2, 3, -1, -1);
    run_frame(1'b1, 16, 16, 1, -1, -1);
    run_frame(1'b1, 8, 16, 0, -1, -1);

    mode = 1'b1; img_width = W'(12); img_height = W'(16); start = 1'b1;
    cycle("rej_blk", ERR_OBS);
    start = 1'b0;
    cycle("rej_blk_idle", IDLE_OBS);
    mode = 1'b0; img_width = W'(0); img_height = W'(5); start = 1'b1;
    cycle("rej_w0", ERR_OBS);
    start = 1'b0; advance = 1'b1;
    cycle("idle_adv_ignored", IDLE_OBS);
    advance = 1'b0;

    run_frame(1'b0, 10, 10, 0, -1, 12);
    run_frame(1'b0, 2, 2, 0, -1, -1);
    run_frame(1'b0, 4, 4, 1, 5, -1);
    run_frame(1'b0, 8191, 1, 0, -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/j_scan_counter.md
Name: j_scan_counter

Overview:
- Parametrised 2-D pixel-coordinate generator for image indexing. It replaces the separate single-axis row/column counters.
- Walks an image of programmable width × height in one of two orders:
  - raster: row-major;
  - block: BLK×BLK tiles, row-major inside each tile, tiles row-major across the image.
- Sits between the image-buffer address logic and the block-transform front end. Each `advance` pulse steps to the next pixel; row-wrap and end-of-frame flags are produced.

Parameters:
- WIDTH, 13, bit width of coordinates and dimension inputs.
- BLK, 8, tile edge length in block mode; power of two, 2..64.

Ports:
- clk  in  1  system clock.
- clear  in  1  synchronous active-high reset; sampled on rising edge of clk.
- start  in  1  begin a frame scan; sampled only in IDLE.
- mode  in  1  0 = raster order, 1 = block order; latched on accepted start.
- img_width  in  WIDTH  columns in image; latched on accepted start.
- img_height  in  WIDTH  rows in image; latched on accepted start.
- advance  in  1  step to next coordinate; honoured only while valid=1.
- busy  out  1  high in RUN state.
- valid  out  1  row/col hold a coordinate of the current frame.
- row  out  WIDTH  current pixel row.
- col  out  WIDTH  current pixel column.
- last  out  1  current coordinate is the final pixel of the frame.
- row_wrap  out  1  registered flag: the last advance wrapped to a new image row (raster) or a new tile row (block).
- done  out  1  one-cycle pulse: frame completed.
- err  out  1  one-cycle pulse: start rejected.

Behaviour:
- Reset: clear=1 overrides everything.
  - Next edge: state=IDLE; row=col=0; busy=valid=last=row_wrap=done=err=0.
  - Latched dims and mode are cleared to 0.
- States: IDLE, RUN, DONE.
- IDLE + start:
  - Start is rejected if img_width==0, img_height==0, or (mode=1 and either dimension not a multiple of BLK).
  - Rejected: err pulses one cycle; stay IDLE.
  - Accepted: latch mode/dims; next cycle RUN with row=col=0, busy=valid=1, row_wrap=0.
- RUN without advance: all outputs hold.
- RUN raster advance (col<W-1): col+1; row_wrap=0.
- RUN raster advance (col==W-1, row<H-1): col=0, row+1; row_wrap=1.
- RUN block mode: internal tile origin (tx,ty) plus offsets (ox,oy) in [0,BLK); outputs are col=tx+ox, row=ty+oy. Order of increment:
  - ox;
  - at ox==BLK-1: ox=0, oy+1;
  - at both offsets BLK-1: offsets=0, tx+BLK;
  - at tx==W-BLK: tx=0, ty+BLK, and row_wrap=1.
- row_wrap behaviour: stays high until the next accepted advance, then drops unless that advance wraps again.
- last: combinational from state, high in RUN when row==H-1 and col==W-1 in either mode (block-mode last is the final tile's bottom-right pixel).
- advance while last=1: next cycle DONE.
  - In DONE: valid=busy=0, done=1 for one cycle; row/col return to 0; row_wrap=0.
  - Then IDLE.
- Ignored inputs:
  - start while RUN or DONE is ignored (no err).
  - advance in IDLE or DONE is ignored.
  - img_width, img_height and mode changes during RUN are ignored.
- Simultaneous clear and start/advance: clear wins.
- Arithmetic: all counters are WIDTH bits with no overflow possible. The maximum dimension is 2^WIDTH−1 in raster mode and the largest multiple of BLK below 2^WIDTH in block mode.
- Latency:
  - advance → new coordinate: 1 cycle.
  - start → first valid: 1 cycle.
  - final advance → done: 1 cycle.

Test Plan:
- Raster 3×2 (mode=0, W=3, H=2), advance every 4th cycle:
  - coordinates (r,c) = (0,0),(0,1),(0,2),(1,0),(1,1),(1,2);
  - row_wrap=1 only while at (1,0);
  - last=1 at (1,2);
  - next advance → done pulse, valid=0.
- Block 16×16 (mode=1, BLK=8):
  - first 10 coords (0,0)…(0,7),(1,0),(1,1);
  - coord 64 = (0,8); coord 128 = (8,0) with row_wrap=1;
  - coord 255 = (15,15) with last=1.
- Rejection cases, each giving an err pulse, busy=0 and state IDLE:
  - start with mode=1, W=12, H=16;
  - start with W=0.
- clear asserted mid-frame at (1,1) of raster 10×10:
  - next cycle row=col=0, valid=busy=0, no done pulse;
  - a new start is accepted.
- Ignored inputs during RUN of raster 4×4:
  - start pulse and img_width change to 2 are ignored;
  - row wraps after col=3 and frame ends at (3,3).
- Boundary: raster W=8191, H=1:
  - col reaches 8190 with last=1;
  - no row_wrap ever;
  - done follows the final advance.
